dmem_request_unit: RTL

- Initiator side of the data-memory RAM interface. Takes CPU load/store requests (byte/half/word, signed/unsigned) and drives the word-wide RAM port: write_en, byte address, write data, read data, busy.
- Performs read-modify-write for sub-word stores.
- Sign- or zero-extends sub-word loads.
- Holds the CPU stalled until each access completes or faults.

---
 rtl/dmem_request_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dmem_request_unit.sv
// Data-memory request unit: turns CPU load/store requests into word-wide RAM
// accesses, with read-modify-write for sub-word stores, load extension and a busy timeout.
module dmem_request_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic [31:0] req_rdata,
  output logic        req_done,
  output logic        req_err,
  output logic        stall,
  output logic        ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out,
  input  logic        ram_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_t;

  state_t        state_q, state_d;
  size_t         size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          unsigned_q, unsigned_d;
  logic          store_q, store_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_any;
  logic          fault;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;
  logic [31:0]   merged;

  assign req_any = req_ren | req_wen;
  assign fault   = (req_ren & req_wen)
                 | (req_size == SZ_BAD)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

  // Lane selection for load extraction and sub-word merge uses the latched address.
  always_comb begin
    ld_byte = ram_data_out[{addr_q[1:0], 3'b000} +: 8];
    ld_half = ram_data_out[{addr_q[1], 4'b0000} +: 16];
    merged  = ram_data_out;
    unique case (size_q)
      SZ_BYTE: begin
        ld_ext = {{24{ld_byte[7] & ~unsigned_q}}, ld_byte};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        ld_ext = {{16{ld_half[15] & ~unsigned_q}}, ld_half};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ld_ext = ram_data_out;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unsigned_d = unsigned_q;
    store_d    = store_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata[15:0];
          size_d     = size_t'(req_size);
          unsigned_d = req_unsigned;
          store_d    = req_wen;
          rdata_d    = '0;
          err_d      = 1'b0;
          if (fault) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (req_wen && (req_size == SZ_WORD)) begin
            data_d  = req_wdata;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (ram_busy) begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (store_q) begin
          data_d  = merged;
          state_d = WR;
        end else begin
          rdata_d = ld_ext;
          state_d = DONE;
        end
      end
      WR: begin
        if (ram_busy) begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // NOTE: synchronous reset; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      unsigned_q <= unsigned_d;
      store_q    <= store_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_done     = (state_q == DONE);
  assign req_err      = err_q;
  assign req_rdata    = rdata_q;
  assign stall        = ((state_q == IDLE) & req_any) | (state_q == RD) | (state_q == WR);
  assign ram_addr     = {addr_q[31:2], 2'b00};
  assign ram_data_in  = data_q;
  // Gated by rst so an access abandoned by reset cannot write on the reset edge.
  assign ram_write_en = (state_q == WR) & ~ram_busy & ~rst;

endmodule
